// File: rtl/rv_instr_encoder.sv
// RV32I instruction encoder: packs decoded fields into an instruction word and
// queues it, together with a range error flag, in a small output FIFO.
module rv_instr_encoder #(
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [6:0]       in_opcode,
    input  logic [2:0]       in_funct3,
    input  logic [6:0]       in_funct7,
    input  logic [4:0]       in_rd_addr,
    input  logic [4:0]       in_rs1_addr,
    input  logic [4:0]       in_rs2_addr,
    input  logic [31:0]      in_imm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_instr,
    output logic             out_err,
    output logic [CNT_W-1:0] enc_count,
    output logic [15:0]      err_count
);

    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {
        FMT_R,
        FMT_I,
        FMT_S,
        FMT_B,
        FMT_U,
        FMT_J,
        FMT_BAD
    } fmt_e;

    fmt_e        fmt;
    logic [31:0] enc_word;
    logic        enc_err;

    logic [32:0]      mem_q [FIFO_DEPTH];
    logic [32:0]      mem_d [FIFO_DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [32:0]      last_q, last_d;
    logic [CNT_W-1:0] enc_count_q, enc_count_d;
    logic [15:0]      err_count_q, err_count_d;

    logic full, empty, push, pop;
    logic imm_i_ok, imm_b_ok, imm_j_ok;

    always_comb begin
        fmt = FMT_BAD;
        case (in_opcode)
            7'b0110011:                                     fmt = FMT_R;
            7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011: fmt = FMT_I;
            7'b0100011:                                     fmt = FMT_S;
            7'b1100011:                                     fmt = FMT_B;
            7'b0110111, 7'b0010111:                         fmt = FMT_U;
            7'b1101111:                                     fmt = FMT_J;
            default:                                        fmt = FMT_BAD;
        endcase
    end

    // An immediate fits its field when every bit above the field equals the sign bit.
    assign imm_i_ok = (&in_imm[31:11]) | ~(|in_imm[31:11]);
    assign imm_b_ok = ((&in_imm[31:12]) | ~(|in_imm[31:12])) & ~in_imm[0];
    assign imm_j_ok = ((&in_imm[31:20]) | ~(|in_imm[31:20])) & ~in_imm[0];

    always_comb begin
        enc_word = {in_funct7, in_rs2_addr, in_rs1_addr, in_funct3, in_rd_addr, in_opcode};
        enc_err  = 1'b0;
        case (fmt)
            FMT_I: begin
                enc_word = {in_imm[11:0], in_rs1_addr, in_funct3, in_rd_addr, in_opcode};
                enc_err  = ~imm_i_ok;
            end
            FMT_S: begin
                enc_word = {in_imm[11:5], in_rs2_addr, in_rs1_addr, in_funct3,
                            in_imm[4:0], in_opcode};
                enc_err  = ~imm_i_ok;
            end
            FMT_B: begin
                enc_word = {in_imm[12], in_imm[10:5], in_rs2_addr, in_rs1_addr, in_funct3,
                            in_imm[4:1], in_imm[11], in_opcode};
                enc_err  = ~imm_b_ok;
            end
            FMT_U: begin
                enc_word = {in_imm[31:12], in_rd_addr, in_opcode};
                enc_err  = |in_imm[11:0];
            end
            FMT_J: begin
                enc_word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12],
                            in_rd_addr, in_opcode};
                enc_err  = ~imm_j_ok;
            end
            FMT_BAD: enc_err = 1'b1;
            default: enc_err = 1'b0;
        endcase
    end

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign push  = in_valid && !full;
    assign pop   = !empty && out_ready;

    always_comb begin
        for (int i = 0; i < FIFO_DEPTH; i++) mem_d[i] = mem_q[i];
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        last_d      = last_q;
        enc_count_d = enc_count_q;
        err_count_d = err_count_q;
        if (push) begin
            mem_d[wr_ptr_q[AW-1:0]] = {enc_err, enc_word};
            wr_ptr_d    = wr_ptr_q + {{AW{1'b0}}, 1'b1};
            enc_count_d = enc_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
            if (enc_err && err_count_q != 16'hFFFF) err_count_d = err_count_q + 16'd1;
        end
        // The popped entry is remembered so the outputs hold it once the FIFO drains.
        if (pop) begin
            last_d   = mem_q[rd_ptr_q[AW-1:0]];
            rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            last_q      <= '0;
            enc_count_q <= '0;
            err_count_q <= '0;
        end else begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= mem_d[i];
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            last_q      <= last_d;
            enc_count_q <= enc_count_d;
            err_count_q <= err_count_d;
        end
    end

    assign in_ready  = !full;
    assign out_valid = !empty;
    assign out_instr = empty ? last_q[31:0] : mem_q[rd_ptr_q[AW-1:0]][31:0];
    assign out_err   = empty ? last_q[32]   : mem_q[rd_ptr_q[AW-1:0]][32];
    assign enc_count = enc_count_q;
    assign err_count = err_count_q;

endmodule

// File: tb/tb_rv_instr_encoder.sv
// Directed bench for rv_instr_encoder: encodings, range errors, backpressure,
// concurrent push/pop and asynchronous reset mid-stream.
module tb_rv_instr_encoder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [6:0]  in_opcode = '0;
    logic [2:0]  in_funct3 = '0;
    logic [6:0]  in_funct7 = '0;
    logic [4:0]  in_rd_addr = '0;
    logic [4:0]  in_rs1_addr = '0;
    logic [4:0]  in_rs2_addr = '0;
    logic [31:0] in_imm = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instr;
    logic        out_err;
    logic [31:0] enc_count;
    logic [15:0] err_count;

    int pass_cnt = 0;
    int total_cnt = 0;
    logic [31:0] exp_q[$];

    rv_instr_encoder #(.FIFO_DEPTH(4), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_opcode(in_opcode), .in_funct3(in_funct3), .in_funct7(in_funct7),
        .in_rd_addr(in_rd_addr), .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr),
        .in_imm(in_imm),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_err(out_err),
        .enc_count(enc_count), .err_count(err_count)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_fields(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                              input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic [31:0] imm);
        in_opcode = op; in_funct3 = f3; in_funct7 = f7;
        in_rd_addr = rd; in_rs1_addr = rs1; in_rs2_addr = rs2; in_imm = imm;
    endtask

    // Single accept into an empty FIFO with out_ready low, leaving the word at the head.
    task automatic send_one();
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    task automatic pop_one();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    // ADDI x(k), x0, k : a unique word per sequence number k.
    function automatic logic [31:0] seq_word(input int k);
        return (32'(k) << 20) | (32'(k) << 7) | 32'h13;
    endfunction

    task automatic test_reset();
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b exp=0", out_valid); else pass_cnt++;
        total_cnt++; if (out_instr !== 32'h0) $display("FAIL reset_out_instr got=%h exp=0", out_instr); else pass_cnt++;
        total_cnt++; if (out_err !== 1'b0) $display("FAIL reset_out_err got=%b exp=0", out_err); else pass_cnt++;
        total_cnt++; if (enc_count !== 32'd0) $display("FAIL reset_enc_count got=%0d exp=0", enc_count); else pass_cnt++;
        total_cnt++; if (err_count !== 16'd0) $display("FAIL reset_err_count got=%0d exp=0", err_count); else pass_cnt++;
        #3 rst_n = 1'b1;
        step();
        total_cnt++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got=%b exp=1", in_ready); else pass_cnt++;
    endtask

    task automatic test_addi();
        set_fields(7'b0010011, 3'd0, 7'd0, 5'd1, 5'd2, 5'd0, 32'd5);
        send_one();
        total_cnt++; if (out_valid !== 1'b1) $display("FAIL addi_valid got=%b exp=1", out_valid); else pass_cnt++;
        total_cnt++; if (out_instr !== 32'h00510093) $display("FAIL addi_instr got=%h exp=00510093", out_instr); else pass_cnt++;
        total_cnt++; if (out_err !== 1'b0) $display("FAIL addi_err got=%b exp=0", out_err); else pass_cnt++;
        total_cnt++; if (enc_count !== 32'd1) $display("FAIL addi_enc_count got=%0d exp=1", enc_count); else pass_cnt++;
        pop_one();
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL addi_drained got=%b exp=0", out_valid); else pass_cnt++;
        total_cnt++; if (out_instr !== 32'h00510093) $display("FAIL addi_hold got=%h exp=00510093", out_instr); else pass_cnt++;
    endtask

    task automatic test_branch_jump();
        set_fields(7'b1100011, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, -32'sd8);
        send_one();
        total_cnt++; if (out_instr !== 32'hFE208CE3) $display("FAIL beq_instr got=%h exp=FE208CE3", out_instr); else pass_cnt++;
        total_cnt++; if (out_err !== 1'b0) $display("FAIL beq_err got=%b exp=0", out_err); else pass_cnt++;
        pop_one();
        set_fields(7'b1101111, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd2048);
        send_one();
        total_cnt++; if (out_instr !== 32'h001000EF) $display("FAIL jal_instr got=%h exp=001000EF", out_instr); else pass_cnt++;
        total_cnt++; if (out_err !== 1'b0) $display("FAIL jal_err got=%b exp=0", out_err); else pass_cnt++;
        pop_one();
        total_cnt++; if (err_count !== 16'd0) $display("FAIL bj_err_count got=%0d exp=0", err_count); else pass_cnt++;
    endtask

    task automatic test_range_errors();
        set_fields(7'b0010011, 3'd0, 7'd0, 5'd1, 5'd2, 5'd0, 32'd2048);
        send_one();
        total_cnt++; if (out_err !== 1'b1) $display("FAIL addi_big_err got=%b exp=1", out_err); else pass_cnt++;
        total_cnt++; if (out_instr !== 32'h80010093) $display("FAIL addi_big_instr got=%h exp=80010093", out_instr); else pass_cnt++;
        pop_one();
        set_fields(7'b1100011, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'd3);
        send_one();
        total_cnt++; if (out_err !== 1'b1) $display("FAIL beq_odd_err got=%b exp=1", out_err); else pass_cnt++;
        pop_one();
        set_fields(7'b0110111, 3'd0, 7'd0, 5'd3, 5'd0, 5'd0, 32'h12345001);
        send_one();
        total_cnt++; if (out_err !== 1'b1) $display("FAIL lui_low_err got=%b exp=1", out_err); else pass_cnt++;
        total_cnt++; if (out_instr !== 32'h123451B7) $display("FAIL lui_instr got=%h exp=123451B7", out_instr); else pass_cnt++;
        pop_one();
        total_cnt++; if (err_count !== 16'd3) $display("FAIL err_count_3 got=%0d exp=3", err_count); else pass_cnt++;
        set_fields(7'b1111111, 3'd0, 7'h20, 5'd1, 5'd2, 5'd3, 32'hDEADBEEF);
        send_one();
        total_cnt++; if (out_err !== 1'b1) $display("FAIL bad_op_err got=%b exp=1", out_err); else pass_cnt++;
        total_cnt++; if (out_instr !== 32'h403100FF) $display("FAIL bad_op_instr got=%h exp=403100FF", out_instr); else pass_cnt++;
        pop_one();
        total_cnt++; if (err_count !== 16'd4) $display("FAIL err_count_4 got=%0d exp=4", err_count); else pass_cnt++;
        total_cnt++; if (enc_count !== 32'd7) $display("FAIL enc_count_7 got=%0d exp=7", enc_count); else pass_cnt++;
    endtask

    task automatic test_backpressure();
        logic [31:0] w [5];
        logic [31:0] base;
        base = enc_count;
        for (int k = 0; k < 5; k++) w[k] = seq_word(k + 1);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int k = 0; k < 4; k++) begin
            set_fields(7'b0010011, 3'd0, 7'd0, 5'(k + 1), 5'd0, 5'd0, 32'(k + 1));
            total_cnt++; if (in_ready !== 1'b1) $display("FAIL bp_fill_ready%0d got=%b exp=1", k, in_ready); else pass_cnt++;
            step();
        end
        set_fields(7'b0010011, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'd5);
        total_cnt++; if (in_ready !== 1'b0) $display("FAIL bp_full_ready got=%b exp=0", in_ready); else pass_cnt++;
        step();
        total_cnt++; if (enc_count !== base + 32'd4) $display("FAIL bp_no_accept got=%0d exp=%0d", enc_count, base + 32'd4); else pass_cnt++;
        total_cnt++; if (out_instr !== w[0]) $display("FAIL bp_head0 got=%h exp=%h", out_instr, w[0]); else pass_cnt++;
        out_ready = 1'b1;
        step();
        total_cnt++; if (in_ready !== 1'b1) $display("FAIL bp_ready_after_pop got=%b exp=1", in_ready); else pass_cnt++;
        for (int k = 1; k < 5; k++) begin
            total_cnt++; if (out_valid !== 1'b1 || out_instr !== w[k]) $display("FAIL bp_order%0d got=%h exp=%h", k, out_instr, w[k]); else pass_cnt++;
            step();
            in_valid = 1'b0;
        end
        out_ready = 1'b0;
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL bp_drained got=%b exp=0", out_valid); else pass_cnt++;
        total_cnt++; if (enc_count !== base + 32'd5) $display("FAIL bp_enc_count got=%0d exp=%0d", enc_count, base + 32'd5); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] base;
        base = enc_count;
        exp_q.delete();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int k = 0; k < 2; k++) begin
            set_fields(7'b0010011, 3'd0, 7'd0, 5'(k + 10), 5'd0, 5'd0, 32'(k + 10));
            exp_q.push_back(seq_word(k + 10));
            step();
        end
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            set_fields(7'b0010011, 3'd0, 7'd0, 5'(i + 12), 5'd0, 5'd0, 32'(i + 12));
            total_cnt++; if (out_valid !== 1'b1 || out_instr !== exp_q[0]) $display("FAIL pp_head%0d got=%h exp=%h", i, out_instr, exp_q[0]); else pass_cnt++;
            step();
            void'(exp_q.pop_front());
            exp_q.push_back(seq_word(i + 12));
            total_cnt++; if (enc_count !== base + 32'(i + 3)) $display("FAIL pp_count%0d got=%0d exp=%0d", i, enc_count, base + 32'(i + 3)); else pass_cnt++;
        end
        in_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            total_cnt++; if (out_valid !== 1'b1 || out_instr !== exp_q[0]) $display("FAIL pp_drain%0d got=%h exp=%h", i, out_instr, exp_q[0]); else pass_cnt++;
            step();
            void'(exp_q.pop_front());
        end
        out_ready = 1'b0;
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL pp_empty got=%b exp=0", out_valid); else pass_cnt++;
    endtask

    task automatic test_reset_midstream();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int k = 0; k < 3; k++) begin
            set_fields(7'b1111111, 3'd0, 7'd0, 5'(k), 5'd0, 5'd0, 32'd0);
            step();
        end
        in_valid = 1'b0;
        total_cnt++; if (out_valid !== 1'b1) $display("FAIL mid_queued got=%b exp=1", out_valid); else pass_cnt++;
        #2 rst_n = 1'b0;
        #1;
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL mid_out_valid got=%b exp=0", out_valid); else pass_cnt++;
        total_cnt++; if (enc_count !== 32'd0) $display("FAIL mid_enc_count got=%0d exp=0", enc_count); else pass_cnt++;
        total_cnt++; if (err_count !== 16'd0) $display("FAIL mid_err_count got=%0d exp=0", err_count); else pass_cnt++;
        total_cnt++; if (out_instr !== 32'h0) $display("FAIL mid_out_instr got=%h exp=0", out_instr); else pass_cnt++;
        step();
        #2 rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            total_cnt++; if (out_valid !== 1'b0 || in_ready !== 1'b1) $display("FAIL mid_stale%0d got=%b/%b exp=0/1", i, out_valid, in_ready); else pass_cnt++;
        end
        out_ready = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        test_addi();
        test_branch_jump();
        test_range_errors();
        test_backpressure();
        test_back_to_back();
        test_reset_midstream();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/rv_instr_encoder.md
Name: rv_instr_encoder

Overview:
- Inverse of the pipeline's instruction field decoder: packs opcode, funct3, funct7, register addresses and a 32-bit immediate into a legal RV32I instruction word.
- Used by the debug/program-loader path to generate instructions for injection into instruction memory or the fetch stage.
- Valid/ready input, registered encode into an output FIFO, valid/ready output.
- Per-instruction range error flag and running statistics counters.

Parameters:
- FIFO_DEPTH, 4, output FIFO entries; power of two, ≥2.
- CNT_W, 32, width of enc_count.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  field bundle valid.
- in_ready  out  1  encoder can accept a bundle.
- in_opcode  in  7  opcode, bits [6:0] of the result.
- in_funct3  in  3  funct3.
- in_funct7  in  7  funct7; used by R-type only.
- in_rd_addr  in  5  destination register.
- in_rs1_addr  in  5  source register 1.
- in_rs2_addr  in  5  source register 2.
- in_imm  in  32  sign-extended immediate, byte offset for branches and jumps.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  consumer accepts the head.
- out_instr  out  32  encoded instruction at the FIFO head.
- out_err  out  1  error flag stored with out_instr.
- enc_count  out  CNT_W  bundles accepted; wraps around.
- err_count  out  16  bundles accepted with error; saturates at 16'hFFFF.

Behaviour:
- Reset (async assert, sync release): FIFO empty, out_valid=0, out_instr=0, out_err=0, enc_count=0, err_count=0. in_ready=1 once reset deasserts.
- Accept occurs when in_valid && in_ready. in_ready = !full. There is no pass-through when full, even if out_ready=1 in the same cycle.
- Latency: a bundle accepted in cycle N appears at out_valid/out_instr in cycle N+1 if the FIFO was empty. Full throughput of 1 per cycle while not full.
- Pop occurs when out_valid && out_ready. Simultaneous push and pop when the FIFO is non-full and non-empty leaves occupancy unchanged.
- FIFO pointers wrap modulo FIFO_DEPTH. Full/empty is tracked with an extra pointer bit. Order is preserved.
- Format select by opcode:
  - 0110011 R.
  - 0010011, 0000011, 1100111, 1110011 I.
  - 0100011 S.
  - 1100011 B.
  - 0110111, 0010111 U.
  - 1101111 J.
  - Any other opcode: error; encoded as R-type.
- Encoding (high to low; op = opcode):
  - R: funct7 | rs2 | rs1 | f3 | rd | op.
  - I: imm[11:0] | rs1 | f3 | rd | op.
  - S: imm[11:5] | rs2 | rs1 | f3 | imm[4:0] | op.
  - B: imm[12] | imm[10:5] | rs2 | rs1 | f3 | imm[4:1] | imm[11] | op.
  - U: imm[31:12] | rd | op.
  - J: imm[20] | imm[10:1] | imm[11] | imm[19:12] | rd | op.
- Error conditions; the word is still encoded from the truncated fields and still enqueued:
  - I/S: imm[31:11] not all equal.
  - B: imm[31:12] not all equal, or imm[0]=1.
  - J: imm[31:20] not all equal, or imm[0]=1.
  - U: imm[11:0] ≠ 0.
  - R: imm is ignored and never causes an error.
  - Unknown opcode.
- Counters: enc_count increments on every accept. err_count increments on each accept with error, holding at max.
- out_instr/out_err reflect the FIFO head. When empty they hold the last popped value; 0 after reset.
- Reset asserted mid-stream: FIFO contents are discarded immediately and counters clear. Nothing is emitted after release until a new accept.

Test Plan:
- ADDI: op=0010011, f3=0, rd=1, rs1=2, imm=5 → next cycle out_instr=32'h00510093, out_err=0, enc_count=1.
- Branch and jump:
  - BEQ: op=1100011, rs1=1, rs2=2, imm=-8 → out_instr=32'hFE208CE3.
  - JAL: op=1101111, rd=1, imm=2048 → 32'h001000EF.
  - No errors on either.
- Range errors:
  - ADDI imm=2048 → out_err=1, out_instr=32'h80010093 (truncated).
  - BEQ imm=3 → out_err=1.
  - LUI op=0110111 imm=32'h12345001 → out_err=1.
  - After all three, err_count=3.
- Backpressure: out_ready=0, drive 5 back-to-back bundles with FIFO_DEPTH=4 → in_ready drops after 4 accepts. Raise out_ready → 4 words emerge in order, 5th accepted, in_ready=1 the cycle after first pop.
- Simultaneous push/pop at 2 entries for 10 cycles → occupancy stays 2, sequence order intact, enc_count increments each accept.
- Assert rst_n low with 3 entries queued → out_valid=0 and counters=0 immediately, without waiting for a clock edge. After release, in_ready=1 and no stale words are emitted.
